// File: rtl/dmem_arbiter_if.sv
// Purpose: bundles the two requester ports, the busy flag and the SRAM pins of
//          dmem_arbiter so that the arbiter and its environment share one port.
// Ports (signals):
//   m0_*/m1_* : req, we, addr, wdata (requester -> arbiter), ack, rdata (arbiter -> requester)
//   busy      : arbiter not idle
//   CEN/WEN/OEN/A/D : SRAM strobes, address and write data (arbiter -> SRAM)
//   Q         : SRAM read data (SRAM -> arbiter)
// Modports: slave = arbiter side, master = requesters plus SRAM side.
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 32
);
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_ack;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_ack;
  logic [DATA_W-1:0] m1_rdata;

  logic              busy;
  logic              CEN;
  logic              WEN;
  logic              OEN;
  logic [ADDR_W-1:0] A;
  logic [DATA_W-1:0] D;
  logic [DATA_W-1:0] Q;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  Q,
    output m0_ack, m0_rdata, m1_ack, m1_rdata,
    output busy, CEN, WEN, OEN, A, D
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output Q,
    input  m0_ack, m0_rdata, m1_ack, m1_rdata,
    input  busy, CEN, WEN, OEN, A, D
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Purpose: shares one single-port data SRAM between two requesters (m0: CPU
//          load/store path, m1: loader/debug port). Arbitrates, latches the
//          winning request, drives SRAM strobes for 1+WAIT_CYC cycles and
//          returns a one-cycle ack with registered read data.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active-high
//   bus  : dmem_arbiter_if.slave (requester handshakes, busy, SRAM pins)
// Parameters: ADDR_W (SRAM word address width), DATA_W (data width),
//   WAIT_CYC (extra CEN-low cycles after the first access cycle, 0..15).
// Configuration macro: DMEM_ARB_FIXED_PRI_EN -- when defined m0 always wins a
//   tie (m1 may starve); when undefined ties alternate round-robin.
module dmem_arbiter #(
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned WAIT_CYC = 1
) (
  input  logic            clk,
  input  logic            rst,
  dmem_arbiter_if.slave   bus
);

  localparam int unsigned CNT_W     = 4;
  localparam int unsigned WAIT_LAST = (WAIT_CYC == 0) ? 0 : WAIT_CYC - 1;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                gnt_q, gnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   d_q, d_d;
  logic                cen_q, cen_d;
  logic                wen_q, wen_d;
  logic                busy_q, busy_d;
  logic                ack0_q, ack0_d;
  logic                ack1_q, ack1_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;
  logic                win_c;
`ifdef DMEM_ARB_FIXED_PRI_EN
`else
  logic                last_q, last_d;
`endif

  // Winner among current requesters (1 = m1)
  always_comb begin
    win_c = bus.m1_req;
    if (bus.m0_req && bus.m1_req) begin
`ifdef DMEM_ARB_FIXED_PRI_EN
      win_c = 1'b0;
`else
      win_c = ~last_q;
`endif
    end
  end

  // Next state; registered outputs are derived from the next state
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gnt_d    = gnt_q;
    we_d     = we_q;
    a_d      = a_q;
    d_d      = d_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
`ifdef DMEM_ARB_FIXED_PRI_EN
`else
    last_d   = last_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.m0_req || bus.m1_req) begin
          state_d = ACCESS;
          gnt_d   = win_c;
          we_d    = win_c ? bus.m1_we    : bus.m0_we;
          a_d     = win_c ? bus.m1_addr  : bus.m0_addr;
          d_d     = win_c ? bus.m1_wdata : bus.m0_wdata;
`ifdef DMEM_ARB_FIXED_PRI_EN
`else
          last_d  = win_c;
`endif
        end
      end
      ACCESS: begin
        cnt_d   = '0;
        state_d = (WAIT_CYC == 0) ? RESP : WAIT;
      end
      WAIT: begin
        if (cnt_q == CNT_W'(WAIT_LAST)) state_d = RESP;
        else                            cnt_d   = cnt_q + CNT_W'(1);
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    cen_d  = !((state_d == ACCESS) || (state_d == WAIT));
    wen_d  = cen_d ? 1'b1 : ~we_d;
    busy_d = (state_d != IDLE);

    // Entering RESP is the edge that leaves the last CEN-low cycle: capture Q
    if (state_d == RESP) begin
      ack0_d = ~gnt_q;
      ack1_d = gnt_q;
      if (!we_q) begin
        if (gnt_q) rdata1_d = bus.Q;
        else       rdata0_d = bus.Q;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      gnt_q    <= 1'b0;
      we_q     <= 1'b0;
      a_q      <= '0;
      d_q      <= '0;
      cen_q    <= 1'b1;
      wen_q    <= 1'b1;
      busy_q   <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      we_q     <= we_d;
      a_q      <= a_d;
      d_q      <= d_d;
      cen_q    <= cen_d;
      wen_q    <= wen_d;
      busy_q   <= busy_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

`ifdef DMEM_ARB_FIXED_PRI_EN
`else
  // Last granted port; reset to m1 so the first tie goes to m0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end
`endif

  assign bus.CEN      = cen_q;
  assign bus.WEN      = wen_q;
  assign bus.OEN      = 1'b0;
  assign bus.A        = a_q;
  assign bus.D        = d_q;
  assign bus.busy     = busy_q;
  assign bus.m0_ack   = ack0_q;
  assign bus.m1_ack   = ack1_q;
  assign bus.m0_rdata = rdata0_q;
  assign bus.m1_rdata = rdata1_q;

endmodule
